// File: rtl/dmem_bus_responder.sv
// MEM-stage data port responder: turns one pipeline load/store request into a single
// transaction on a valid/ready split read/write bus and stalls the pipeline until it ends.
module dmem_bus_responder #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // MEM-stage request
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_stall,
  output logic [31:0]       mem_rdata,
  output logic              stallreq_from_mem,
  output logic              bus_err,
  // read address channel
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  // read data channel
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  // write address channel
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  // write data channel
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  // write response channel
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;
  logic              aw_done_q;
  logic              w_done_q;

  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  // Address and data phases of a write may complete in either order or together.
  assign aw_ok = aw_done_q | aw_hs;
  assign w_ok  = w_done_q | w_hs;

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= 2'd0;
      sel_q     <= 4'd0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      mem_rdata <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem_en) begin
            addr_q    <= mem_addr;
            // Size 3 has no wider meaning on a 32-bit bus; issue it as a word.
            size_q    <= (mem_size == 2'd3) ? 2'd2 : mem_size;
            sel_q     <= mem_sel;
            wdata_q   <= mem_wdata;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (mem_we) begin
              state_q <= StWrReq;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state_q <= StRdAddr;
              arvalid <= 1'b1;
            end
          end
        end
        StRdAddr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRdData;
          end
        end
        StRdData: begin
          if (rvalid) begin
            mem_rdata <= rdata;
            bus_err   <= |rresp;
            rready    <= 1'b0;
            state_q   <= StDone;
          end
        end
        StWrReq: begin
          if (aw_hs) begin
            awvalid   <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid   <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready  <= 1'b1;
            state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (bvalid) begin
            bus_err <= |bresp;
            bready  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          // The stalled pipeline keeps presenting the finished request; wait it out.
          if (!mem_stall) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stallreq_from_mem = 1'b0;
    if (rst) begin
      case (state_q)
        StIdle:  stallreq_from_mem = mem_en;
        StDone:  stallreq_from_mem = 1'b0;
        default: stallreq_from_mem = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Directed bench for dmem_bus_responder: a table of single transactions against a
// delay-programmable bus slave, plus hand sequences for DONE hold and mid-read reset.
module tb_dmem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic [1:0]  mem_size;
  logic        stallreq_from_mem, bus_err;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;

  dmem_bus_responder #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .stallreq_from_mem(stallreq_from_mem), .bus_err(bus_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [2:0]  exp_size;
    int          exp_stall;
    int          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
  endtask

  // Issues one request, plays the bus slave with the vector's delays, and returns in
  // the DONE cycle; with finish set it also retires the request and checks the cycle after.
  task automatic run_txn(input vec_t v, input string nm, input bit finish);
    int cyc, stall_cyc, err_cyc, ar_hs, aw_hs, w_hs, awv_cyc, wv_cyc;
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit done, early_b, err_at_done;
    logic [31:0] cap_addr, cap_wdata;
    logic [2:0]  cap_size;
    logic [3:0]  cap_strb;
    cyc = 0; stall_cyc = 0; err_cyc = 0; ar_hs = 0; aw_hs = 0; w_hs = 0;
    awv_cyc = 0; wv_cyc = 0; ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    done = 1'b0; early_b = 1'b0; err_at_done = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_size = '0; cap_strb = '0;
    @(posedge clk); #1;
    mem_en = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_size = v.size;
    mem_sel = v.sel; mem_wdata = v.wdata; mem_stall = 1'b0;
    while (!done && cyc < 40) begin
      arready = arvalid && (ar_wait >= v.ar_dly);
      rvalid  = rready && (r_wait >= v.r_dly);
      rdata   = v.rdata; rresp = v.resp;
      awready = awvalid && (aw_wait >= v.aw_dly);
      wready  = wvalid && (w_wait >= v.w_dly);
      bvalid  = bready && (b_wait >= v.b_dly);
      bresp   = v.resp;
      #1;
      err_cyc += int'(bus_err);
      if (cyc > 0 && !stallreq_from_mem) begin
        done = 1'b1;
        err_at_done = bus_err;
      end else begin
        stall_cyc += int'(stallreq_from_mem);
        awv_cyc += int'(awvalid);
        wv_cyc += int'(wvalid);
        if (bready && (aw_hs == 0 || w_hs == 0)) early_b = 1'b1;
        if (arvalid && arready) begin ar_hs++; cap_addr = araddr; cap_size = arsize; end
        if (awvalid && awready) begin aw_hs++; cap_addr = awaddr; cap_size = awsize; end
        if (wvalid && wready) begin w_hs++; cap_wdata = wdata; cap_strb = wstrb; end
        if (arvalid) ar_wait++;
        if (rready) r_wait++;
        if (awvalid) aw_wait++;
        if (wvalid) w_wait++;
        if (bready) b_wait++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    slave_idle();
    check({nm, "_completed"}, 64'(done), 64'd1);
    check({nm, "_stall_cycles"}, 64'(stall_cyc), 64'(v.exp_stall));
    check({nm, "_bus_err_cycles"}, 64'(err_cyc), 64'(v.exp_err));
    check({nm, "_bus_err_at_done"}, 64'(err_at_done), 64'(v.exp_err));
    check({nm, "_addr"}, 64'(cap_addr), 64'(v.addr));
    check({nm, "_size"}, 64'(cap_size), 64'(v.exp_size));
    if (!v.we) begin
      exp_rd = v.rdata;
      check({nm, "_ar_handshakes"}, 64'(ar_hs), 64'd1);
      check({nm, "_aw_handshakes"}, 64'(aw_hs), 64'd0);
    end else begin
      check({nm, "_aw_handshakes"}, 64'(aw_hs), 64'd1);
      check({nm, "_w_handshakes"}, 64'(w_hs), 64'd1);
      check({nm, "_ar_handshakes"}, 64'(ar_hs), 64'd0);
      check({nm, "_wstrb"}, 64'(cap_strb), 64'(v.sel));
      check({nm, "_wdata"}, 64'(cap_wdata), 64'(v.wdata));
      check({nm, "_awvalid_cycles"}, 64'(awv_cyc), 64'(v.aw_dly + 1));
      check({nm, "_wvalid_cycles"}, 64'(wv_cyc), 64'(v.w_dly + 1));
      check({nm, "_bready_early"}, 64'(early_b), 64'd0);
    end
    check({nm, "_mem_rdata"}, 64'(mem_rdata), 64'(exp_rd));
    if (finish) begin
      mem_en = 1'b0;
      @(posedge clk); #2;
      check({nm, "_after_bus_err"}, 64'(bus_err), 64'd0);
      check({nm, "_after_stall"}, 64'(stallreq_from_mem), 64'd0);
      check({nm, "_after_rdata"}, 64'(mem_rdata), 64'(exp_rd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vh;
    vec_t vr;
    //          we   addr          sz    sel      wdata          rdata          rsp  ar r aw w b sz  st er
    vecs[0] = '{1'b0, 32'h1FC0_0010, 2'd2, 4'hF,    32'h0,         32'hDEAD_BEEF, 2'd0, 0,1,0,0,0, 3'd2, 4, 0};
    vecs[1] = '{1'b1, 32'h8000_0005, 2'd0, 4'b0010, 32'h0000_AB00, 32'h0,         2'd0, 0,0,0,0,0, 3'd0, 3, 0};
    vecs[2] = '{1'b1, 32'h8000_0100, 2'd2, 4'hF,    32'h1122_3344, 32'h0,         2'd0, 0,0,0,3,0, 3'd2, 6, 0};
    vecs[3] = '{1'b0, 32'h0000_0040, 2'd2, 4'hF,    32'h0,         32'h1234_5678, 2'd2, 0,0,0,0,0, 3'd2, 3, 1};
    vecs[4] = '{1'b0, 32'h0000_0080, 2'd3, 4'hF,    32'h0,         32'hCAFE_F00D, 2'd0, 2,0,0,0,0, 3'd2, 5, 0};
    vecs[5] = '{1'b1, 32'h0010_0002, 2'd1, 4'b1100, 32'hABCD_0000, 32'h0,         2'd3, 0,0,0,0,1, 3'd1, 4, 1};
    vecs[6] = '{1'b0, 32'h0000_0002, 2'd1, 4'b0011, 32'h0,         32'h0000_5A5A, 2'd0, 1,0,0,0,0, 3'd1, 4, 0};
    vh      = '{1'b0, 32'h0000_0300, 2'd2, 4'hF,    32'h0,         32'h55AA_55AA, 2'd0, 0,0,0,0,0, 3'd2, 3, 0};
    vr      = '{1'b0, 32'h1FC0_0020, 2'd2, 4'hF,    32'h0,         32'h0BAD_CAFE, 2'd0, 0,0,0,0,0, 3'd2, 3, 0};

    // Reset state; a pending request must not raise a stall while in reset.
    rst = 1'b0;
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1000; mem_sel = 4'hF;
    mem_size = 2'd2; mem_wdata = 32'd0; mem_stall = 1'b0;
    slave_idle();
    #12;
    check("reset_handshake_and_stall",
          64'({arvalid, rready, awvalid, wvalid, bready, stallreq_from_mem, bus_err}), 64'd0);
    check("reset_mem_rdata", 64'(mem_rdata), 64'd0);
    check("reset_araddr", 64'(araddr), 64'd0);
    mem_en = 1'b0;
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Completed read held in DONE by mem_stall while the same request stays presented.
    run_txn(vh, "hold", 1'b0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("hold_stallreq", 64'(stallreq_from_mem), 64'd0);
      check("hold_no_arvalid", 64'(arvalid), 64'd0);
    end
    @(posedge clk); #1;
    mem_stall = 1'b0;
    #1;
    check("hold_release_stallreq", 64'(stallreq_from_mem), 64'd0);
    @(posedge clk); #1;
    mem_addr = 32'h0000_0304;
    #1;
    // Only IDLE with a request raises the stall, so this proves DONE was left.
    check("hold_idle_next_cycle", 64'(stallreq_from_mem), 64'd1);
    mem_en = 1'b0;
    @(posedge clk); #2;
    check("hold_no_reissue", 64'(arvalid), 64'd0);
    check("hold_rdata_stable", 64'(mem_rdata), 64'h55AA_55AA);

    // Reset asserted while waiting in RD_DATA.
    @(posedge clk); #1;
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0200; mem_size = 2'd2;
    arready = 1'b1; rvalid = 1'b0;
    @(posedge clk); #1;
    check("midrst_arvalid", 64'(arvalid), 64'd1);
    @(posedge clk); #1;
    check("midrst_in_rd_data", 64'(rready), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_handshake_and_stall",
          64'({arvalid, rready, awvalid, wvalid, bready, stallreq_from_mem, bus_err}), 64'd0);
    check("midrst_mem_rdata", 64'(mem_rdata), 64'd0);
    exp_rd = 32'd0;
    mem_en = 1'b0;
    slave_idle();
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    run_txn(vr, "post_reset_read", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
